// File: rtl/async_fifo_write_logic.sv
// rtl/async_fifo_write_logic.sv - write-side pointer and full-flag logic for a dual-clock FIFO
module async_fifo_write_logic #(
    parameter int PTR_SZ = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              winc,
    input  logic [PTR_SZ:0]   rq2_raddr,
    output logic              wfull,
    output logic              write_en,
    output logic [PTR_SZ-1:0] waddr,
    output logic [PTR_SZ:0]   waddr_gray
);

    // In Gray code a pointer exactly one lap ahead differs only in its top two bits.
    localparam logic [PTR_SZ:0] WRAP_MASK = {2'b11, {(PTR_SZ-1){1'b0}}};

    logic [PTR_SZ:0] wbin;
    logic [PTR_SZ:0] wbin_next;
    logic [PTR_SZ:0] wgray_next;
    logic [PTR_SZ:0] full_ptr;

    assign write_en   = winc & ~wfull;
    assign wbin_next  = wbin + {{PTR_SZ{1'b0}}, write_en};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign full_ptr   = rq2_raddr ^ WRAP_MASK;
    assign waddr      = wbin[PTR_SZ-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin       <= '0;
            waddr_gray <= '0;
            wfull      <= 1'b0;
        end else begin
            wbin       <= wbin_next;
            waddr_gray <= wgray_next;
            wfull      <= (wgray_next == full_ptr);
        end
    end

endmodule

// File: tb/tb_async_fifo_write_logic.sv
// tb/tb_async_fifo_write_logic.sv - self-checking bench for async_fifo_write_logic
module tb_async_fifo_write_logic;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       winc = 1'b0;
    logic [2:0] rq2_raddr = 3'b000;
    logic       wfull;
    logic       write_en;
    logic [1:0] waddr;
    logic [2:0] waddr_gray;

    int checks = 0;
    int failures = 0;

    // Reference model: write count and read count as plain integers modulo 8.
    int m_wbin = 0;
    bit m_full = 1'b0;
    int r_bin = 0;

    async_fifo_write_logic #(.PTR_SZ(2)) dut (
        .clk(clk),
        .rst(rst),
        .winc(winc),
        .rq2_raddr(rq2_raddr),
        .wfull(wfull),
        .write_en(write_en),
        .waddr(waddr),
        .waddr_gray(waddr_gray)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] to_gray(input int b);
        logic [2:0] v;
        v = 3'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic int from_gray(input logic [2:0] g);
        int b;
        b = 0;
        for (int i = 2; i >= 0; i--) b = b | (((b >> (i + 1)) & 1) ^ int'(g[i])) << i;
        return b;
    endfunction

    // One clock: drive inputs after the falling edge, check comb strobe, then registered outputs.
    task automatic step(input logic w, input logic [2:0] rq);
        bit exp_we;
        int rb;
        @(negedge clk);
        winc = w;
        rq2_raddr = rq;
        #1;
        exp_we = w && !m_full;
        checks++;
        if (write_en !== exp_we) begin
            failures++;
            $display("FAIL write_en: got %b expected %b", write_en, exp_we);
        end
        rb = from_gray(rq);
        m_wbin = (m_wbin + int'(exp_we)) % 8;
        // Full when the write pointer is exactly one lap ahead of the read pointer.
        m_full = (((m_wbin - rb) % 8 + 8) % 8) == 4;
        @(posedge clk);
        #1;
        checks++;
        if (waddr !== 2'(m_wbin % 4)) begin
            failures++;
            $display("FAIL waddr: got %0d expected %0d", waddr, m_wbin % 4);
        end
        checks++;
        if (waddr_gray !== to_gray(m_wbin)) begin
            failures++;
            $display("FAIL waddr_gray: got %b expected %b", waddr_gray, to_gray(m_wbin));
        end
        checks++;
        if (wfull !== m_full) begin
            failures++;
            $display("FAIL wfull: got %b expected %b", wfull, m_full);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        winc = 1'b0;
        rq2_raddr = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({waddr, waddr_gray, wfull, write_en} !== 7'b0) begin
            failures++;
            $display("FAIL reset_state: got waddr=%0d gray=%b full=%b we=%b expected all zero",
                     waddr, waddr_gray, wfull, write_en);
        end
        winc = 1'b1;
        #1;
        checks++;
        if (write_en !== 1'b1) begin
            failures++;
            $display("FAIL reset_we_follows_winc: got %b expected 1", write_en);
        end
        winc = 1'b0;
        rst = 1'b0;
        m_wbin = 0;
        m_full = 1'b0;
        r_bin = 0;
    endtask

    task automatic test_fill;
        logic [1:0] exp_addr [4];
        logic [2:0] exp_gray [4];
        exp_addr = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_gray = '{3'b001, 3'b011, 3'b010, 3'b110};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'b000);
            checks++;
            if (waddr !== exp_addr[i] || waddr_gray !== exp_gray[i] || wfull !== (i == 3)) begin
                failures++;
                $display("FAIL fill[%0d]: got addr=%0d gray=%b full=%b expected addr=%0d gray=%b full=%b",
                         i, waddr, waddr_gray, wfull, exp_addr[i], exp_gray[i], i == 3);
            end
            step(1'b0, 3'b000);
        end
    endtask

    task automatic test_write_while_full;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 3'b000);
            checks++;
            if (waddr !== 2'd0 || waddr_gray !== 3'b110 || wfull !== 1'b1) begin
                failures++;
                $display("FAIL overflow_hold[%0d]: got addr=%0d gray=%b full=%b expected addr=0 gray=110 full=1",
                         i, waddr, waddr_gray, wfull);
            end
        end
    endtask

    task automatic test_read_release;
        r_bin = 1;
        step(1'b0, 3'b001);
        checks++;
        if (wfull !== 1'b0) begin
            failures++;
            $display("FAIL release: got wfull=%b expected 0", wfull);
        end
        step(1'b1, 3'b001);
        checks++;
        if (waddr !== 2'd1 || waddr_gray !== 3'b111 || wfull !== 1'b1) begin
            failures++;
            $display("FAIL refill: got addr=%0d gray=%b full=%b expected addr=1 gray=111 full=1",
                     waddr, waddr_gray, wfull);
        end
    endtask

    task automatic test_full_hold;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b001);
            checks++;
            if (waddr !== 2'd1 || waddr_gray !== 3'b111 || wfull !== 1'b1) begin
                failures++;
                $display("FAIL full_hold[%0d]: got addr=%0d gray=%b full=%b expected addr=1 gray=111 full=1",
                         i, waddr, waddr_gray, wfull);
            end
        end
    endtask

    task automatic test_random;
        int occ;
        for (int i = 0; i < 300; i++) begin
            occ = ((m_wbin - r_bin) % 8 + 8) % 8;
            if (occ != 0 && $urandom_range(0, 2) == 0) r_bin = (r_bin + 1) % 8;
            step(1'($urandom_range(0, 3) != 0), to_gray(r_bin));
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 5; i++) step(1'b1, to_gray(r_bin));
        checks++;
        if (wfull !== 1'b1) begin
            failures++;
            $display("FAIL prefill_full: got %b expected 1", wfull);
        end
        @(posedge clk);
        #3;
        winc = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({waddr, waddr_gray, wfull, write_en} !== 7'b0) begin
            failures++;
            $display("FAIL async_reset: got waddr=%0d gray=%b full=%b we=%b expected all zero",
                     waddr, waddr_gray, wfull, write_en);
        end
        @(negedge clk);
        rst = 1'b0;
        m_wbin = 0;
        m_full = 1'b0;
        r_bin = 0;
        step(1'b1, 3'b000);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_while_full();
        test_read_release();
        test_full_hold();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
